// File: rtl/ad9467_ddr_capture_wr_if.sv
// AXI4 write-only bundle (AW/W/B) between the ADC capture engine and the DDR3 controller.
// Data width is fixed at 512 bits to match the controller's native port.
interface ad9467_ddr_capture_wr_if #(
    parameter int C_ID_WIDTH   = 2,
    parameter int C_ADDR_WIDTH = 32
);
    logic [C_ID_WIDTH-1:0]   awid;
    logic [C_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;
    logic [511:0]            wdata;
    logic [63:0]             wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [C_ID_WIDTH-1:0]   bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/ad9467_ddr_capture_wr.sv
// Packs 64-bit AD9467 words into 512-bit beats, buffers them in a beat FIFO and writes
// them to DDR3 as fixed-length AXI4 INCR bursts, one burst outstanding at a time.
module ad9467_ddr_capture_wr #(
    parameter int C_ID_WIDTH   = 2,
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_BURST_LEN  = 16,
    parameter int C_FIFO_DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    ddr_ready,
    input  logic                    capture_start,
    input  logic [C_ADDR_WIDTH-1:0] capture_base,
    input  logic [15:0]             capture_bursts,
    input  logic                    adc_valid,
    input  logic [63:0]             adc_data,
    output logic                    capture_busy,
    output logic                    capture_done,
    output logic                    capture_ovf,
    output logic                    capture_err,
    ad9467_ddr_capture_wr_if.master m_axi
);
    localparam int BL_W   = $clog2(C_BURST_LEN);
    localparam int BEAT_W = 16 + BL_W;
    localparam int PTR_W  = $clog2(C_FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * 64);
    localparam logic [C_ADDR_WIDTH-1:0] ALIGN_MASK  = C_ADDR_WIDTH'(C_BURST_LEN * 64 - 1);
    localparam logic [BL_W-1:0]         LAST_BEAT   = BL_W'(C_BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

    state_t                  r_state, w_state_next;
    logic [C_ADDR_WIDTH-1:0] r_awaddr;
    logic [15:0]             r_bursts_left;
    logic [BEAT_W-1:0]       r_beats_left;
    logic [BL_W-1:0]         r_beat_cnt;
    logic [2:0]              r_lane;
    logic [447:0]            r_pack;
    logic                    r_ovf, r_err;
    logic [511:0]            r_fifo_mem [C_FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]        r_mem_cnt;
    logic                    r_out_valid;
    logic [511:0]            r_wdata;

    logic             w_start_ok, w_accept, w_beat_done, w_full, w_push, w_pop, w_load;
    logic [CNT_W-1:0] w_fifo_cnt;
    logic             w_unused_bid;

    assign w_start_ok  = capture_start && ddr_ready && (capture_bursts != 16'd0)
                         && (r_state == S_IDLE || r_state == S_DONE);
    // Packing stops once enough beats have actually been pushed, so dropped beats are
    // made up from later ADC words and every burst still gets C_BURST_LEN beats.
    assign w_accept    = capture_busy && adc_valid && (r_beats_left != '0);
    assign w_beat_done = w_accept && (r_lane == 3'd7);
    // The output register counts as a FIFO slot.
    assign w_fifo_cnt  = r_mem_cnt + CNT_W'(r_out_valid);
    assign w_full      = (w_fifo_cnt == CNT_W'(C_FIFO_DEPTH));
    assign w_push      = w_beat_done && !w_full;
    assign w_pop       = m_axi.wvalid && m_axi.wready;
    assign w_load      = (r_mem_cnt != '0) && (!r_out_valid || w_pop);

    always_ff @(posedge clk) begin
        if (w_accept && r_lane != 3'd7) r_pack[r_lane*64 +: 64] <= adc_data;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= {adc_data, r_pack};
        if (w_load) r_wdata <= r_fifo_mem[r_rd_ptr];
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= S_IDLE;
            r_awaddr      <= '0;
            r_bursts_left <= '0;
            r_beats_left  <= '0;
            r_beat_cnt    <= '0;
            r_lane        <= '0;
            r_ovf         <= 1'b0;
            r_err         <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_mem_cnt     <= '0;
            r_out_valid   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_awaddr      <= capture_base & ~ALIGN_MASK;
                r_bursts_left <= capture_bursts;
                r_beats_left  <= BEAT_W'(capture_bursts) << BL_W;
                r_lane        <= '0;
                r_ovf         <= 1'b0;
                r_err         <= 1'b0;
            end else begin
                if (w_accept) r_lane <= r_lane + 3'd1;
                if (w_push) r_beats_left <= r_beats_left - BEAT_W'(1);
                if (w_beat_done && w_full) r_ovf <= 1'b1;
                if (m_axi.awvalid && m_axi.awready) r_awaddr <= r_awaddr + BURST_BYTES;
                if (w_pop) r_beat_cnt <= r_beat_cnt + BL_W'(1);
                if (m_axi.bvalid && m_axi.bready) begin
                    r_bursts_left <= r_bursts_left - 16'd1;
                    if (m_axi.bresp != 2'b00) r_err <= 1'b1;
                end
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_load) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_mem_cnt <= r_mem_cnt + CNT_W'(w_push) - CNT_W'(w_load);
            if (w_load)     r_out_valid <= 1'b1;
            else if (w_pop) r_out_valid <= 1'b0;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        capture_busy  = 1'b0;
        capture_done  = 1'b0;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_next = S_WAIT;
            S_WAIT: begin
                capture_busy = 1'b1;
                if (w_fifo_cnt >= CNT_W'(C_BURST_LEN)) w_state_next = S_ADDR;
            end
            S_ADDR: begin
                capture_busy  = 1'b1;
                m_axi.awvalid = 1'b1;
                if (m_axi.awready) w_state_next = S_DATA;
            end
            S_DATA: begin
                capture_busy = 1'b1;
                m_axi.wvalid = r_out_valid;
                if (w_pop && r_beat_cnt == LAST_BEAT) w_state_next = S_RESP;
            end
            S_RESP: begin
                capture_busy = 1'b1;
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) w_state_next = (r_bursts_left == 16'd1) ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                capture_done = 1'b1;
                w_state_next = w_start_ok ? S_WAIT : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = r_awaddr;
    assign m_axi.awlen   = 8'(C_BURST_LEN - 1);
    assign m_axi.awsize  = 3'b110;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awqos   = 4'b0000;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = (r_beat_cnt == LAST_BEAT);
    assign capture_ovf   = r_ovf;
    assign capture_err   = r_err;
    assign w_unused_bid  = ^m_axi.bid;
endmodule

// File: tb/tb_ad9467_ddr_capture_wr.sv
// Randomized bench: a behavioural word-queue/address model checks every AXI handshake,
// plus literal expectations for addresses and packed data of the basic capture.
module tb_ad9467_ddr_capture_wr;
    logic        clk = 1'b0;
    logic        aresetn, ddr_ready, capture_start;
    logic [31:0] capture_base;
    logic [15:0] capture_bursts;
    logic        adc_valid;
    logic [63:0] adc_data;
    logic        capture_busy, capture_done, capture_ovf, capture_err;

    ad9467_ddr_capture_wr_if #(.C_ID_WIDTH(2), .C_ADDR_WIDTH(32)) axi ();

    ad9467_ddr_capture_wr #(.C_ID_WIDTH(2), .C_ADDR_WIDTH(32), .C_BURST_LEN(16), .C_FIFO_DEPTH(32)) dut (
        .clk(clk), .aresetn(aresetn), .ddr_ready(ddr_ready), .capture_start(capture_start),
        .capture_base(capture_base), .capture_bursts(capture_bursts),
        .adc_valid(adc_valid), .adc_data(adc_data),
        .capture_busy(capture_busy), .capture_done(capture_done),
        .capture_ovf(capture_ovf), .capture_err(capture_err), .m_axi(axi));

    always #5 clk = ~clk;

    int tests_run = 0, tests_failed = 0;

    // stimulus / slave knobs
    int aw_pct = 100, w_pct = 100, b_pct = 100, adc_pct = 100;
    bit w_stall = 0, check_data = 0;
    int err_burst = -1;
    int words_left = 0, seq = 0;
    // model state
    logic [63:0] exp_words[$];
    logic [31:0] aw_log[$];
    logic [31:0] exp_addr;
    logic [511:0] first_beat, last_beat;
    int aw_cnt, w_cnt, done_cnt, b_idx, b_pending, outstanding, beat_in_burst;
    bit wlast_hs_f, b_hs_f;
    bit hold_aw, hold_w;
    logic [31:0] held_awaddr;
    logic [511:0] held_wdata;
    logic held_wlast;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_word(input int s);
        return {16'(4*s+3), 16'(4*s+2), 16'(4*s+1), 16'(4*s)};
    endfunction

    task automatic reset_model(input logic [31:0] base);
        exp_words.delete(); aw_log.delete();
        exp_addr = base & ~32'h3FF;
        aw_cnt = 0; w_cnt = 0; done_cnt = 0; b_idx = 0; b_pending = 0;
        outstanding = 0; beat_in_burst = 0; seq = 0; words_left = 0;
        wlast_hs_f = 0; b_hs_f = 0;
    endtask

    // Monitor at negedge: values seen here are the ones the next posedge will sample.
    always @(negedge clk) begin
        if (!aresetn) begin
            hold_aw = 0; hold_w = 0;
        end else begin
            if (hold_aw) chk("aw_stable", {31'd0, axi.awvalid, axi.awaddr}, {31'd0, 1'b1, held_awaddr});
            if (hold_w) begin
                tests_run++;
                if (!(axi.wvalid === 1'b1 && axi.wdata === held_wdata && axi.wlast === held_wlast)) begin
                    tests_failed++;
                    $display("FAIL w_stable: wvalid=%b wlast=%b data_changed=%b", axi.wvalid, axi.wlast, axi.wdata !== held_wdata);
                end
            end
            hold_aw = axi.awvalid && !axi.awready; held_awaddr = axi.awaddr;
            hold_w  = axi.wvalid && !axi.wready;  held_wdata = axi.wdata; held_wlast = axi.wlast;

            if (axi.awvalid && axi.awready) begin
                chk("awaddr", {32'd0, axi.awaddr}, {32'd0, exp_addr});
                chk("aw_const", {37'd0, axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot, axi.awqos},
                    {37'd0, 2'd0, 8'd15, 3'b110, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
                chk("one_outstanding", 64'(outstanding), 64'd0);
                aw_log.push_back(axi.awaddr);
                exp_addr = exp_addr + 32'h400;
                aw_cnt++; outstanding++;
            end
            if (axi.wvalid && axi.wready) begin
                logic [511:0] eb;
                chk("w_after_aw", 64'(w_cnt < aw_cnt*16), 64'd1);
                chk("wlast", {63'd0, axi.wlast}, {63'd0, beat_in_burst == 15});
                chk("wstrb", axi.wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
                if (check_data) begin
                    tests_run++;
                    if (exp_words.size() < 8) begin
                        tests_failed++;
                        $display("FAIL wdata: beat %0d has no expected words (model holds %0d)", w_cnt, exp_words.size());
                    end else begin
                        for (int k = 0; k < 8; k++) eb[64*k +: 64] = exp_words.pop_front();
                        if (axi.wdata !== eb) begin
                            tests_failed++;
                            $display("FAIL wdata: beat %0d lane0 got %h expected %h", w_cnt, axi.wdata[63:0], eb[63:0]);
                        end
                    end
                end
                if (w_cnt == 0) first_beat = axi.wdata;
                last_beat = axi.wdata;
                if (axi.wlast) wlast_hs_f = 1;
                w_cnt++;
                beat_in_burst = (beat_in_burst + 1) % 16;
            end
            if (axi.bvalid && axi.bready) begin
                b_hs_f = 1; outstanding--;
            end
            if (capture_done) done_cnt++;
        end
    end

    // Slave and ADC drivers, updated just after each active edge.
    always @(posedge clk) begin
        #1;
        if (!aresetn) begin
            axi.bvalid = 0; axi.awready = 0; axi.wready = 0; adc_valid = 0;
        end else begin
            if (b_hs_f) begin axi.bvalid = 0; b_hs_f = 0; end
            if (wlast_hs_f) begin b_pending++; wlast_hs_f = 0; end
            if (!axi.bvalid && b_pending > 0 && $urandom_range(99) < b_pct) begin
                axi.bvalid = 1;
                axi.bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
                b_idx++; b_pending--;
            end
            axi.awready = ($urandom_range(99) < aw_pct);
            axi.wready  = !w_stall && ($urandom_range(99) < w_pct);
            if (words_left > 0 && $urandom_range(99) < adc_pct) begin
                adc_valid = 1;
                adc_data  = mk_word(seq);
                if (check_data) exp_words.push_back(adc_data);
                seq++; words_left--;
            end else begin
                adc_valid = 0;
            end
        end
    end

    task automatic pulse_start(input logic [31:0] base, input logic [15:0] n);
        @(posedge clk); #2;
        capture_base = base; capture_bursts = n; capture_start = 1;
        @(posedge clk); #2;
        capture_start = 0;
    endtask

    task automatic run_case(input string name, input logic [31:0] base, input int bursts,
                            input int awp, input int wp, input int stall, input int eb,
                            input bit exp_ovf, input bit exp_err, input bit data, input bit poke);
        int cyc;
        reset_model(base);
        aw_pct = awp; w_pct = wp; b_pct = wp; err_burst = eb; check_data = data;
        adc_pct = data ? 70 : 100;
        w_stall = (stall > 0);
        pulse_start(base, 16'(bursts));
        words_left = data ? bursts * 128 : 1000000;
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(posedge clk); #2;
            cyc++;
            if (cyc == stall) w_stall = 0;
            if (poke && cyc == 60) begin
                capture_base = 32'h7000_0000; capture_bursts = 16'd5; capture_start = 1;
            end
            if (poke && cyc == 61) capture_start = 0;
        end
        if (done_cnt == 0) begin
            tests_run++; tests_failed++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, cyc);
        end
        words_left = 0; w_stall = 0;
        repeat (5) @(posedge clk);
        #2;
        chk({name, "_done_once"}, 64'(done_cnt), 64'd1);
        chk({name, "_aw_count"}, 64'(aw_cnt), 64'(bursts));
        chk({name, "_w_count"}, 64'(w_cnt), 64'(bursts * 16));
        chk({name, "_busy_after"}, {63'd0, capture_busy}, 64'd0);
        chk({name, "_ovf"}, {63'd0, capture_ovf}, {63'd0, exp_ovf});
        chk({name, "_err"}, {63'd0, capture_err}, {63'd0, exp_err});
        if (data) chk({name, "_words_left"}, 64'(exp_words.size()), 64'd0);
        $display("[TB] case %s: bursts=%0d aw=%0d beats=%0d ovf=%b err=%b", name, bursts, aw_cnt, w_cnt, capture_ovf, capture_err);
    endtask

    initial begin
        aresetn = 0; ddr_ready = 1; capture_start = 0; capture_base = '0; capture_bursts = '0;
        adc_valid = 0; adc_data = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00; axi.bid = 2'b00;
        reset_model(32'h0);
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {57'd0, axi.awvalid, axi.wvalid, axi.bready, capture_busy, capture_done, capture_ovf, capture_err}, 64'd0);
        aresetn = 1;
        repeat (2) @(posedge clk);

        // 1: basic capture, always-ready slave, ignored restart while busy
        run_case("basic", 32'h1000_0000, 2, 100, 100, 0, -1, 0, 0, 1, 1);
        chk("basic_aw0", {32'd0, aw_log[0]}, 64'h1000_0000);
        chk("basic_aw1", {32'd0, aw_log[1]}, 64'h1000_0400);
        chk("basic_beat0_lane1", first_beat[127:64], 64'h0007_0006_0005_0004);
        chk("basic_beat31_lane7", last_beat[511:448], 64'h03FF_03FE_03FD_03FC);

        // 2: random back-pressure on every channel
        run_case("random_ready", 32'h1000_0000, 2, 50, 50, 0, -1, 0, 0, 1, 0);
        chk("random_aw1", {32'd0, aw_log[1]}, 64'h1000_0400);

        // 3: unaligned base, then starts that must be ignored
        run_case("unaligned", 32'h1000_0123, 1, 60, 60, 0, -1, 0, 0, 1, 0);
        chk("unaligned_aw0", {32'd0, aw_log[0]}, 64'h1000_0000);
        reset_model(32'h0);
        pulse_start(32'h2000_0000, 16'd0);
        repeat (30) @(posedge clk);
        #2;
        chk("zero_bursts_ignored", {62'd0, capture_busy, axi.awvalid}, 64'd0);
        ddr_ready = 0;
        pulse_start(32'h2000_0000, 16'd2);
        words_left = 256;
        repeat (30) @(posedge clk);
        #2;
        chk("not_ready_ignored", {31'd0, capture_busy, 32'(aw_cnt)}, 64'd0);
        words_left = 0; ddr_ready = 1;
        repeat (3) @(posedge clk);

        // 4: long wready stall with continuous ADC -> overflow but completion
        run_case("overflow", 32'h3000_0000, 4, 100, 100, 400, -1, 1, 0, 0, 0);

        // 5: SLVERR on the first of three bursts
        run_case("bresp_err", 32'h4000_0000, 3, 70, 70, 0, 0, 0, 1, 1, 0);

        // 6: reset in the middle of DATA, then a clean capture
        reset_model(32'h5000_0000);
        aw_pct = 100; w_pct = 30; b_pct = 100; err_burst = -1; check_data = 0; adc_pct = 100;
        pulse_start(32'h5000_0000, 16'd2);
        words_left = 1000000;
        begin
            int cyc = 0;
            while (w_cnt < 3 && cyc < 5000) begin @(posedge clk); #2; cyc++; end
            chk("midreset_reached_data", 64'(w_cnt >= 3), 64'd1);
        end
        #1 aresetn = 0;
        #1;
        chk("midreset_outputs", {57'd0, axi.awvalid, axi.wvalid, axi.bready, capture_busy, capture_done, capture_ovf, capture_err}, 64'd0);
        words_left = 0;
        repeat (3) @(posedge clk);
        #2 aresetn = 1;
        repeat (2) @(posedge clk);
        run_case("after_reset", 32'h2000_0000, 2, 50, 50, 0, -1, 0, 0, 1, 0);
        chk("after_reset_aw0", {32'd0, aw_log[0]}, 64'h2000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
